// File: rtl/egress_frame_arbiter.sv
// Whole-frame arbiter that shares one port's 9-bit transmit path among REQUESTERS queue sources.
// Define EGRESS_FRAME_ARBITER_STRICT_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module egress_frame_arbiter #(
  parameter int REQUESTERS             = 4,
  parameter int INTER_FRAME_GAP_CYCLES = 12,
  parameter int MAX_FRAME_BYTES        = 1522
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [9*REQUESTERS-1:0] request_data,
  input  logic [REQUESTERS-1:0]   request_valid,
  output logic [REQUESTERS-1:0]   request_ready,
  output logic [8:0]              transmit_data,
  output logic                    transmit_data_enable,
  input  logic                    transmit_data_ready,
  output logic [REQUESTERS-1:0]   grant,
  output logic                    busy,
  output logic                    frame_truncated
);

  localparam int IDX_W = $clog2(REQUESTERS);
  localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam int GAP_W = (INTER_FRAME_GAP_CYCLES > 1) ? $clog2(INTER_FRAME_GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(INTER_FRAME_GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(REQUESTERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FORWARD,
    DRAIN,
    GAP
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;
  logic              pick_valid;
  logic [CNT_W-1:0]  byte_count;
  logic [GAP_W-1:0]  gap_count;
  logic [8:0]        lane;
  logic              lane_valid;
  logic              beat_moves;
  logic              at_limit;

  assign lane       = request_data[owner*9 +: 9];
  assign lane_valid = request_valid[owner];
  assign beat_moves = lane_valid && transmit_data_ready;
  assign at_limit   = (byte_count == LAST_BEAT);

  // Descending search so the final assignment is the highest-priority candidate.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
`ifdef EGRESS_FRAME_ARBITER_STRICT_PRIORITY_EN
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (request_valid[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
`else
    for (int off = REQUESTERS; off >= 1; off--) begin
      cand = IDX_W'((int'(last) + off) % REQUESTERS);
      if (request_valid[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (enable && pick_valid) next_state = FORWARD;
      FORWARD: if (beat_moves && lane[8]) next_state = GAP;
               else if (beat_moves && at_limit) next_state = DRAIN;
      DRAIN:   if (lane_valid && lane[8]) next_state = GAP;
      GAP:     if (gap_count == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // An EOF on the limit beat takes the normal-EOF path, so no truncation pulse is raised.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant           <= '0;
      owner           <= '0;
      last            <= LAST_INIT;
      byte_count      <= '0;
      gap_count       <= '0;
      frame_truncated <= 1'b0;
    end else begin
      frame_truncated <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable && pick_valid) begin
            owner      <= pick;
            grant      <= {{(REQUESTERS-1){1'b0}}, 1'b1} << pick;
            byte_count <= '0;
          end
        end
        FORWARD: begin
          if (beat_moves) begin
            byte_count <= byte_count + CNT_W'(1);
            if (lane[8]) begin
              last      <= owner;
              gap_count <= GAP_LOAD;
              grant     <= '0;
            end else if (at_limit) begin
              last            <= owner;
              frame_truncated <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (lane_valid && lane[8]) begin
            gap_count <= GAP_LOAD;
            grant     <= '0;
          end
        end
        GAP: begin
          if (gap_count != '0) gap_count <= gap_count - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    request_ready        = '0;
    transmit_data        = '0;
    transmit_data_enable = 1'b0;
    busy                 = (state != IDLE);
    unique case (state)
      FORWARD: begin
        transmit_data        = lane;
        if (at_limit) transmit_data[8] = 1'b1;
        transmit_data_enable = lane_valid;
        request_ready[owner] = transmit_data_ready;
      end
      DRAIN:   request_ready[owner] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_egress_frame_arbiter.sv
// Directed self-checking bench for egress_frame_arbiter; a second instance with MAX_FRAME_BYTES=16 covers truncation.
`timescale 1ns/1ps
module tb_egress_frame_arbiter;

  localparam int R = 4;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic transmit_data_ready;
  logic [9*R-1:0] request_data;
  logic [R-1:0] request_valid;

  logic [R-1:0] rr_a, grant_a, rr_b, grant_b;
  logic [8:0] td_a, td_b;
  logic tde_a, tde_b, busy_a, busy_b, trunc_a, trunc_b;

  always #5 clock = ~clock;

  egress_frame_arbiter #(.REQUESTERS(R), .INTER_FRAME_GAP_CYCLES(12), .MAX_FRAME_BYTES(1522)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .request_data(request_data), .request_valid(request_valid), .request_ready(rr_a),
    .transmit_data(td_a), .transmit_data_enable(tde_a), .transmit_data_ready(transmit_data_ready),
    .grant(grant_a), .busy(busy_a), .frame_truncated(trunc_a)
  );

  egress_frame_arbiter #(.REQUESTERS(R), .INTER_FRAME_GAP_CYCLES(12), .MAX_FRAME_BYTES(16)) dut_trunc (
    .clock(clock), .reset(reset), .enable(enable),
    .request_data(request_data), .request_valid(request_valid), .request_ready(rr_b),
    .transmit_data(td_b), .transmit_data_enable(tde_b), .transmit_data_ready(transmit_data_ready),
    .grant(grant_b), .busy(busy_b), .frame_truncated(trunc_b)
  );

  int errors = 0;
  int checks = 0;

  bit sel = 1'b0;
  bit toggle_ready = 1'b0;
  int src_len [R];
  int src_pos [R];
  bit src_act [R];
  bit src_cont [R];
  logic [8:0] out_q [$];

  logic [R-1:0] obs_grant, obs_rr, obs_valid;
  logic [8:0] obs_td;
  logic obs_tde, obs_busy, obs_trunc, obs_ready;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] beatVal(input int lane, input int pos, input int len);
    logic [7:0] b;
    b = 8'(lane * 64 + pos);
    return {(pos == len - 1), b};
  endfunction

  function automatic logic [3:0] fairExp(input int k);
`ifdef EGRESS_FRAME_ARBITER_STRICT_PRIORITY_EN
    return 4'b0001;
`else
    return 4'b0001 << (k % 4);
`endif
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < R; i++) begin
      request_valid[i]      = src_act[i];
      request_data[9*i +: 9] = src_act[i] ? beatVal(i, src_pos[i], src_len[i]) : 9'h000;
    end
  endtask

  task automatic startFrame(input int lane, input int len, input bit cont);
    src_act[lane]  = 1'b1;
    src_pos[lane]  = 0;
    src_len[lane]  = len;
    src_cont[lane] = cont;
  endtask

  task automatic stopAll();
    for (int i = 0; i < R; i++) src_act[i] = 1'b0;
  endtask

  // Observe at the falling edge, then advance sources for beats taken on the rising edge.
  task automatic tick();
    bit xfer [R];
    @(negedge clock);
    obs_grant = sel ? grant_b : grant_a;
    obs_rr    = sel ? rr_b    : rr_a;
    obs_td    = sel ? td_b    : td_a;
    obs_tde   = sel ? tde_b   : tde_a;
    obs_busy  = sel ? busy_b  : busy_a;
    obs_trunc = sel ? trunc_b : trunc_a;
    obs_ready = transmit_data_ready;
    obs_valid = request_valid;
    for (int i = 0; i < R; i++) xfer[i] = src_act[i] && obs_rr[i];
    if (obs_tde && obs_ready) out_q.push_back(obs_td);
    @(posedge clock);
    #1;
    for (int i = 0; i < R; i++) begin
      if (xfer[i]) begin
        if (src_pos[i] == src_len[i] - 1) begin
          src_pos[i] = 0;
          if (!src_cont[i]) src_act[i] = 1'b0;
        end else begin
          src_pos[i]++;
        end
      end
    end
    if (toggle_ready) transmit_data_ready = ~transmit_data_ready;
    applyStimulus();
  endtask

  task automatic doReset();
    reset = 1'b1;
    stopAll();
    toggle_ready = 1'b0;
    transmit_data_ready = 1'b1;
    enable = 1'b1;
    applyStimulus();
    tick();
    tick();
    reset = 1'b0;
    out_q.delete();
    applyStimulus();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int good, gapc, cyc, n, pulses, pulse_at, drained, stable_err, mirror_err, grant1;
    logic [3:0] prev;
    logic [3:0] seq [6];
    bit prev_hold;
    logic [8:0] prev_td;

    reset = 1'b1;
    enable = 1'b0;
    transmit_data_ready = 1'b0;
    stopAll();
    applyStimulus();
    tick();
    tick();
    checkOutput("rst_grant", obs_grant, 0);
    checkOutput("rst_busy", obs_busy, 0);
    checkOutput("rst_tde", obs_tde, 0);
    checkOutput("rst_td", obs_td, 0);
    checkOutput("rst_rr", obs_rr, 0);
    checkOutput("rst_trunc", obs_trunc, 0);

    // Single 64-beat frame from requester 2
    sel = 1'b0;
    doReset();
    startFrame(2, 64, 1'b0);
    applyStimulus();
    tick();
    checkOutput("t1_idle_grant", obs_grant, 0);
    tick();
    checkOutput("t1_grant", obs_grant, 4'b0100);
    for (int k = 0; k < 63; k++) tick();
    checkOutput("t1_count", out_q.size(), 64);
    good = 0;
    for (int k = 0; k < out_q.size(); k++) if (out_q[k] === beatVal(2, k, 64)) good++;
    checkOutput("t1_data", good, 64);
    gapc = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (obs_grant == 0 && obs_busy && !obs_tde) gapc++;
    end
    checkOutput("t1_gap", gapc, 12);
    tick();
    checkOutput("t1_busy_end", obs_busy, 0);

    // Fairness with four continuous 10-beat sources
    doReset();
    for (int i = 0; i < R; i++) startFrame(i, 10, 1'b1);
    applyStimulus();
    prev = 0;
    n = 0;
    cyc = 0;
    while (n < 6 && cyc < 400) begin
      tick();
      cyc++;
      if (obs_grant != 0 && prev == 0) begin
        seq[n] = obs_grant;
        n++;
      end
      prev = obs_grant;
    end
    checkOutput("t2_grants", n, 6);
    for (int k = 0; k < 6; k++) checkOutput($sformatf("t2_grant%0d", k), seq[k], fairExp(k));

    // Backpressure with ready toggling every cycle
    doReset();
    startFrame(1, 20, 1'b0);
    toggle_ready = 1'b1;
    applyStimulus();
    stable_err = 0;
    mirror_err = 0;
    prev_hold = 1'b0;
    prev_td = '0;
    cyc = 0;
    while (out_q.size() < 20 && cyc < 200) begin
      tick();
      cyc++;
      if (prev_hold && (!obs_tde || obs_td !== prev_td)) stable_err++;
      if (obs_grant == 4'b0010 && obs_rr !== (obs_ready ? 4'b0010 : 4'b0000)) mirror_err++;
      prev_hold = obs_tde && !obs_ready;
      prev_td = obs_td;
    end
    toggle_ready = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    checkOutput("t3_count", out_q.size(), 20);
    good = 0;
    for (int k = 0; k < out_q.size(); k++) if (out_q[k] === beatVal(1, k, 20)) good++;
    checkOutput("t3_data", good, 20);
    checkOutput("t3_stable", stable_err, 0);
    checkOutput("t3_mirror", mirror_err, 0);

    // Truncation on the MAX_FRAME_BYTES=16 instance
    sel = 1'b1;
    doReset();
    startFrame(1, 20, 1'b0);
    applyStimulus();
    pulses = 0;
    pulse_at = -1;
    drained = 0;
    gapc = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (obs_trunc) begin
        pulses++;
        pulse_at = out_q.size();
      end
      if (obs_rr[1] && obs_valid[1] && !obs_tde) drained++;
      if (obs_busy && obs_rr == 0 && !obs_tde) gapc++;
    end
    checkOutput("t4_count", out_q.size(), 16);
    good = 0;
    for (int k = 0; k < 15 && k < out_q.size(); k++) if (out_q[k] === beatVal(1, k, 20)) good++;
    checkOutput("t4_data", good, 15);
    checkOutput("t4_last_beat", out_q.size() > 15 ? out_q[15] : 9'h000, 9'h14F);
    checkOutput("t4_pulses", pulses, 1);
    checkOutput("t4_pulse_at", pulse_at, 16);
    checkOutput("t4_drained", drained, 4);
    checkOutput("t4_gap", gapc, 12);
    checkOutput("t4_busy_end", obs_busy, 0);

    // Reset in the middle of a frame must also restore the pointer
    sel = 1'b0;
    doReset();
    startFrame(1, 2, 1'b0);
    applyStimulus();
    for (int k = 0; k < 30; k++) tick();
    checkOutput("t5_pre_idle", obs_busy, 0);
    out_q.delete();
    startFrame(3, 30, 1'b0);
    applyStimulus();
    cyc = 0;
    while (out_q.size() < 5 && cyc < 50) begin
      tick();
      cyc++;
    end
    checkOutput("t5_beats", out_q.size(), 5);
    reset = 1'b1;
    src_act[3] = 1'b0;
    startFrame(0, 3, 1'b0);
    startFrame(2, 3, 1'b0);
    applyStimulus();
    tick();
    reset = 1'b0;
    applyStimulus();
    tick();
    checkOutput("t5_grant", obs_grant, 0);
    checkOutput("t5_busy", obs_busy, 0);
    checkOutput("t5_tde", obs_tde, 0);
    checkOutput("t5_td", obs_td, 0);
    checkOutput("t5_rr", obs_rr, 0);
    checkOutput("t5_trunc", obs_trunc, 0);
    tick();
    checkOutput("t5_next_grant", obs_grant, 4'b0001);

    // enable dropped mid-frame
    doReset();
    startFrame(0, 10, 1'b0);
    applyStimulus();
    cyc = 0;
    while (out_q.size() < 3 && cyc < 30) begin
      tick();
      cyc++;
    end
    enable = 1'b0;
    startFrame(1, 5, 1'b0);
    applyStimulus();
    grant1 = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (obs_grant == 4'b0010) grant1++;
    end
    checkOutput("t6_beats", out_q.size(), 10);
    good = 0;
    for (int k = 0; k < out_q.size(); k++) if (out_q[k] === beatVal(0, k, 10)) good++;
    checkOutput("t6_data", good, 10);
    checkOutput("t6_busy", obs_busy, 0);
    checkOutput("t6_nogrant", grant1, 0);
    enable = 1'b1;
    applyStimulus();
    tick();
    checkOutput("t6_latency", obs_grant, 0);
    tick();
    checkOutput("t6_grant", obs_grant, 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
